// File: rtl/lm_access_arbiter.sv
// CPU/DMA arbiter for a shared dual-port local data memory with independent read
// and write channels, a DMA starvation guard and read-during-write byte forwarding.
module lm_access_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_rd_req,
  input  logic [ADDR_W-1:0]   cpu_rd_addr,
  output logic                cpu_rd_gnt,
  output logic                cpu_rd_valid,
  output logic [DATA_W-1:0]   cpu_rd_data,
  input  logic                cpu_wr_req,
  input  logic [ADDR_W-1:0]   cpu_wr_addr,
  input  logic [DATA_W-1:0]   cpu_wr_data,
  input  logic [DATA_W/8-1:0] cpu_wr_be,
  output logic                cpu_wr_gnt,
  input  logic                dma_rd_req,
  input  logic [ADDR_W-1:0]   dma_rd_addr,
  output logic                dma_rd_gnt,
  output logic                dma_rd_valid,
  output logic [DATA_W-1:0]   dma_rd_data,
  input  logic                dma_wr_req,
  input  logic [ADDR_W-1:0]   dma_wr_addr,
  input  logic [DATA_W-1:0]   dma_wr_data,
  input  logic [DATA_W/8-1:0] dma_wr_be,
  output logic                dma_wr_gnt,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_we,
  input  logic [DATA_W-1:0]   mem_q
);

  localparam int         LANES = DATA_W / 8;
  localparam logic [3:0] LIM   = 4'(STARVE_LIM);

  // Channel index 0 = read, 1 = write; both channels use identical arbitration.
  logic [1:0] cpu_req_ch, dma_req_ch, cpu_gnt_ch, dma_gnt_ch;

  assign cpu_req_ch = {cpu_wr_req, cpu_rd_req};
  assign dma_req_ch = {dma_wr_req, dma_rd_req};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [3:0] starve_cnt;
      logic       dma_win;

      assign dma_win        = dma_req_ch[gi] && (!cpu_req_ch[gi] || (starve_cnt == LIM));
      assign dma_gnt_ch[gi] = !reset && dma_win;
      assign cpu_gnt_ch[gi] = !reset && cpu_req_ch[gi] && !dma_win;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          starve_cnt <= '0;
        end else if (dma_req_ch[gi] && !dma_gnt_ch[gi]) begin
          starve_cnt <= (starve_cnt == LIM) ? starve_cnt : starve_cnt + 4'd1;
        end else begin
          starve_cnt <= '0;
        end
      end
    end
  endgenerate

  assign cpu_rd_gnt = cpu_gnt_ch[0];
  assign dma_rd_gnt = dma_gnt_ch[0];
  assign cpu_wr_gnt = cpu_gnt_ch[1];
  assign dma_wr_gnt = dma_gnt_ch[1];

  assign mem_raddr = dma_rd_gnt ? dma_rd_addr : (cpu_rd_gnt ? cpu_rd_addr : '0);
  assign mem_waddr = dma_wr_gnt ? dma_wr_addr : (cpu_wr_gnt ? cpu_wr_addr : '0);
  assign mem_wdata = dma_wr_gnt ? dma_wr_data : (cpu_wr_gnt ? cpu_wr_data : '0);
  assign mem_we    = dma_wr_gnt ? dma_wr_be   : (cpu_wr_gnt ? cpu_wr_be   : '0);

  logic              collide;
  logic              rd_valid_reg;
  logic              rd_owner_reg;   // 1 = outstanding read belongs to DMA
  logic              hit_reg;
  logic [LANES-1:0]  hit_be_reg;
  logic [DATA_W-1:0] hit_data_reg;
  logic [DATA_W-1:0] rd_data;

  // The memory returns old data on a same-word read/write, so remember the write.
  assign collide = (|dma_gnt_ch[0] | cpu_gnt_ch[0]) && (dma_wr_gnt || cpu_wr_gnt)
                   && (mem_raddr == mem_waddr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_owner_reg <= 1'b0;
      hit_reg      <= 1'b0;
      hit_be_reg   <= '0;
      hit_data_reg <= '0;
    end else begin
      rd_valid_reg <= cpu_rd_gnt || dma_rd_gnt;
      rd_owner_reg <= dma_rd_gnt;
      hit_reg      <= collide;
      hit_be_reg   <= mem_we;
      hit_data_reg <= mem_wdata;
    end
  end

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign rd_data[gi*8 +: 8] = (hit_reg && hit_be_reg[gi]) ? hit_data_reg[gi*8 +: 8]
                                                              : mem_q[gi*8 +: 8];
    end
  endgenerate

  assign cpu_rd_data  = rd_data;
  assign dma_rd_data  = rd_data;
  assign cpu_rd_valid = rd_valid_reg && !rd_owner_reg;
  assign dma_rd_valid = rd_valid_reg && rd_owner_reg;

endmodule

// File: tb/tb_lm_access_arbiter.sv
// Directed bench for lm_access_arbiter with a behavioural 1-cycle registered-read
// memory; expected values are hand-computed constants.
module tb_lm_access_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_rd_req, cpu_rd_gnt, cpu_rd_valid;
  logic [11:0] cpu_rd_addr;
  logic [31:0] cpu_rd_data;
  logic        cpu_wr_req, cpu_wr_gnt;
  logic [11:0] cpu_wr_addr;
  logic [31:0] cpu_wr_data;
  logic [3:0]  cpu_wr_be;
  logic        dma_rd_req, dma_rd_gnt, dma_rd_valid;
  logic [11:0] dma_rd_addr;
  logic [31:0] dma_rd_data;
  logic        dma_wr_req, dma_wr_gnt;
  logic [11:0] dma_wr_addr;
  logic [31:0] dma_wr_data;
  logic [3:0]  dma_wr_be;
  logic [11:0] mem_raddr, mem_waddr;
  logic [31:0] mem_wdata, mem_q;
  logic [3:0]  mem_we;

  int n_checks = 0;
  int n_errors = 0;

  lm_access_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIM(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_gnt(cpu_rd_gnt),
    .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_be(cpu_wr_be), .cpu_wr_gnt(cpu_wr_gnt),
    .dma_rd_req(dma_rd_req), .dma_rd_addr(dma_rd_addr), .dma_rd_gnt(dma_rd_gnt),
    .dma_rd_valid(dma_rd_valid), .dma_rd_data(dma_rd_data),
    .dma_wr_req(dma_wr_req), .dma_wr_addr(dma_wr_addr), .dma_wr_data(dma_wr_data),
    .dma_wr_be(dma_wr_be), .dma_wr_gnt(dma_wr_gnt),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte-enabled write, registered read returning pre-write data.
  logic [31:0] mem_arr [0:4095];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) mem_arr[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    mem_q <= mem_arr[mem_raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("  ok   %s = %h", tag, got);
    end
  endtask

  task automatic idle();
    cpu_rd_req = 0; cpu_rd_addr = '0;
    cpu_wr_req = 0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_wr_be = '0;
    dma_rd_req = 0; dma_rd_addr = '0;
    dma_wr_req = 0; dma_wr_addr = '0; dma_wr_data = '0; dma_wr_be = '0;
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    dma_wr_req = 1; dma_wr_addr = a; dma_wr_data = d; dma_wr_be = 4'hF;
    @(posedge clk); #1;
    dma_wr_req = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    // Requests present during reset must not be granted.
    cpu_rd_req = 1; cpu_rd_addr = 12'h005;
    cpu_wr_req = 1; cpu_wr_addr = 12'h006; cpu_wr_data = 32'h12345678; cpu_wr_be = 4'hF;
    #12;
    check("rst_cpu_rd_gnt", {31'b0, cpu_rd_gnt}, 32'd0);
    check("rst_cpu_wr_gnt", {31'b0, cpu_wr_gnt}, 32'd0);
    check("rst_mem_we", {28'b0, mem_we}, 32'd0);
    check("rst_mem_raddr", {20'b0, mem_raddr}, 32'd0);
    check("rst_cpu_rd_valid", {31'b0, cpu_rd_valid}, 32'd0);
    check("rst_dma_rd_valid", {31'b0, dma_rd_valid}, 32'd0);
    @(negedge clk);
    idle();
    reset = 0;

    for (int i = 0; i < 16; i++) load(12'(i), 32'hC0DE0000 + 32'(i));
    load(12'h010, 32'hDEADBEEF);
    load(12'h020, 32'h11223344);
    load(12'h030, 32'h00000000);

    // 1: single CPU read
    @(negedge clk);
    cpu_rd_req = 1; cpu_rd_addr = 12'h010; #1;
    check("t1_cpu_rd_gnt", {31'b0, cpu_rd_gnt}, 32'd1);
    check("t1_dma_rd_gnt", {31'b0, dma_rd_gnt}, 32'd0);
    check("t1_mem_raddr", {20'b0, mem_raddr}, 32'h010);
    @(posedge clk); #1;
    cpu_rd_req = 0;
    check("t1_cpu_rd_valid", {31'b0, cpu_rd_valid}, 32'd1);
    check("t1_cpu_rd_data", cpu_rd_data, 32'hDEADBEEF);
    check("t1_dma_rd_valid", {31'b0, dma_rd_valid}, 32'd0);

    // 2: contended reads, DMA wins every 9th cycle
    @(negedge clk);
    cpu_rd_req = 1; cpu_rd_addr = 12'h001;
    dma_rd_req = 1; dma_rd_addr = 12'h002; #1;
    for (int i = 0; i < 18; i++) begin
      logic dma_turn;
      dma_turn = (i % 9) == 8;
      check($sformatf("t2_dma_gnt[%0d]", i), {31'b0, dma_rd_gnt}, {31'b0, dma_turn});
      check($sformatf("t2_cpu_gnt[%0d]", i), {31'b0, cpu_rd_gnt}, {31'b0, !dma_turn});
      @(posedge clk); #1;
      check($sformatf("t2_dma_valid[%0d]", i), {31'b0, dma_rd_valid}, {31'b0, dma_turn});
      check($sformatf("t2_data[%0d]", i), cpu_rd_data,
            dma_turn ? 32'hC0DE0002 : 32'hC0DE0001);
    end
    idle();

    // 3: CPU read and DMA write to the same word in the same cycle
    @(negedge clk);
    cpu_rd_req = 1; cpu_rd_addr = 12'h020;
    dma_wr_req = 1; dma_wr_addr = 12'h020; dma_wr_data = 32'hAABBCCDD; dma_wr_be = 4'b0101; #1;
    check("t3_cpu_rd_gnt", {31'b0, cpu_rd_gnt}, 32'd1);
    check("t3_dma_wr_gnt", {31'b0, dma_wr_gnt}, 32'd1);
    check("t3_mem_we", {28'b0, mem_we}, 32'h5);
    @(posedge clk); #1;
    idle();
    check("t3_cpu_rd_valid", {31'b0, cpu_rd_valid}, 32'd1);
    check("t3_cpu_rd_data", cpu_rd_data, 32'h11BB33DD);
    @(negedge clk);
    dma_rd_req = 1; dma_rd_addr = 12'h020;
    @(posedge clk); #1;
    dma_rd_req = 0;
    check("t3_mem_after", dma_rd_data, 32'h11BB33DD);

    // 4: contended write (CPU wins), then DMA reads back the partial write
    @(negedge clk);
    cpu_wr_req = 1; cpu_wr_addr = 12'h030; cpu_wr_data = 32'hFF000000; cpu_wr_be = 4'b1000;
    dma_wr_req = 1; dma_wr_addr = 12'h031; dma_wr_data = 32'h0; dma_wr_be = 4'hF; #1;
    check("t4_cpu_wr_gnt", {31'b0, cpu_wr_gnt}, 32'd1);
    check("t4_dma_wr_gnt", {31'b0, dma_wr_gnt}, 32'd0);
    check("t4_mem_we", {28'b0, mem_we}, 32'h8);
    check("t4_mem_waddr", {20'b0, mem_waddr}, 32'h030);
    check("t4_mem_wdata", mem_wdata, 32'hFF000000);
    @(posedge clk); #1;
    cpu_wr_req = 0;
    dma_rd_req = 1; dma_rd_addr = 12'h030; #1;
    check("t4_dma_wr_gnt_next", {31'b0, dma_wr_gnt}, 32'd1);
    check("t4_dma_rd_gnt", {31'b0, dma_rd_gnt}, 32'd1);
    @(posedge clk); #1;
    idle();
    check("t4_dma_rd_valid", {31'b0, dma_rd_valid}, 32'd1);
    check("t4_dma_rd_data", dma_rd_data, 32'hFF000000);

    // 5: reset while a read is granted and the DMA counter is part-way up
    @(negedge clk);
    cpu_rd_req = 1; cpu_rd_addr = 12'h001;
    dma_rd_req = 1; dma_rd_addr = 12'h002;
    cpu_wr_req = 1; cpu_wr_addr = 12'h040; cpu_wr_data = 32'h0BADF00D; cpu_wr_be = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("t5_cpu_rd_gnt_pre", {31'b0, cpu_rd_gnt}, 32'd1);
    check("t5_mem_we_pre", {28'b0, mem_we}, 32'hF);
    #2 reset = 1;
    #1;
    check("t5_cpu_rd_gnt_rst", {31'b0, cpu_rd_gnt}, 32'd0);
    check("t5_dma_rd_gnt_rst", {31'b0, dma_rd_gnt}, 32'd0);
    check("t5_mem_we_rst", {28'b0, mem_we}, 32'd0);
    check("t5_mem_raddr_rst", {20'b0, mem_raddr}, 32'd0);
    check("t5_cpu_rd_valid_rst", {31'b0, cpu_rd_valid}, 32'd0);
    @(posedge clk); #1;
    check("t5_cpu_rd_valid_edge", {31'b0, cpu_rd_valid}, 32'd0);
    @(negedge clk);
    reset = 0; cpu_wr_req = 0; #1;
    check("t5_cpu_rd_valid_rel", {31'b0, cpu_rd_valid}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t5_dma_gnt[%0d]", i), {31'b0, dma_rd_gnt}, {31'b0, i == 8});
      @(posedge clk); #1;
      if (i == 0) check("t5_cpu_rd_valid_resume", {31'b0, cpu_rd_valid}, 32'd1);
    end
    idle();

    // 6: 16 back-to-back DMA reads
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dma_rd_req = 1; dma_rd_addr = 12'(i); #1;
      check($sformatf("t6_gnt[%0d]", i), {31'b0, dma_rd_gnt}, 32'd1);
      @(posedge clk); #1;
      check($sformatf("t6_valid[%0d]", i), {31'b0, dma_rd_valid}, 32'd1);
      check($sformatf("t6_data[%0d]", i), dma_rd_data, 32'hC0DE0000 + 32'(i));
    end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    check("t6_valid_end", {31'b0, dma_rd_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
